// File: rtl/window_scheduler_pkg.sv
// Shared scheduler types and default window geometry.
// The defaults are also used by the CAR filterbank chain.
package window_scheduler_pkg;

  typedef enum logic [1:0] {
    SCH_FILL,
    SCH_START,
    SCH_WAIT,
    SCH_CLEAR
  } sched_state_t;

  localparam int DEF_SAMPLING_RATE = 48;
  localparam int DEF_TIME_WINDOW   = 10;
  localparam int CNT_W             = 16;

endpackage

// File: rtl/window_scheduler_sat_counter.sv
// Saturating up-counter with synchronous clear.
// The counter holds at all-ones and never wraps.
module window_scheduler_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] FULL = '1;

  always_ff @(posedge clk) begin
    if (clear) begin
      value <= '0;
    end else if (inc && (value != FULL)) begin
      value <= value + ONE;
    end
  end

endmodule

// File: rtl/window_scheduler.sv
// Per-window sequencer: fill samples, run one CNN inference,
// then clear the CAR RAMs before reopening the window.
module window_scheduler
  import window_scheduler_pkg::*;
#(
  parameter int SAMPLING_RATE  = DEF_SAMPLING_RATE,
  parameter int TIME_WINDOW    = DEF_TIME_WINDOW,
  parameter int CLEAR_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sound_valid_i,
  output logic        sample_accept_o,
  output logic [15:0] count_samples_o,
  output logic        infer_start_o,
  input  logic        infer_done_i,
  output logic        ram_clear_o,
  output logic [15:0] window_cnt_o,
  output logic [15:0] overrun_cnt_o,
  output logic        timeout_o
);

  localparam int TOTAL_SAMPLES = SAMPLING_RATE * TIME_WINDOW;

  localparam logic [15:0] TOTAL16  = 16'(TOTAL_SAMPLES);
  localparam logic [15:0] CLR_LAST = 16'(CLEAR_CYCLES - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] ONE16    = 16'd1;
  localparam bit          TMO_ON   = (TIMEOUT_CYCLES != 0);

  if (TOTAL_SAMPLES > 65535 || TOTAL_SAMPLES < 1) begin : g_total_chk
    $error("TOTAL_SAMPLES must be in 1..65535");
  end

  if (CLEAR_CYCLES < 1) begin : g_clear_chk
    $error("CLEAR_CYCLES must be at least 1");
  end

  sched_state_t state;
  sched_state_t state_nx;

  logic [15:0] count_nx;
  logic [15:0] tmo;
  logic [15:0] tmo_nx;
  logic [15:0] clr;
  logic [15:0] clr_nx;
  logic [15:0] win_nx;
  logic        timeout_nx;
  logic        overrun;

  assign sample_accept_o = (state == SCH_FILL);
  assign overrun = sound_valid_i && (state != SCH_FILL);

  always_comb begin
    state_nx   = state;
    count_nx   = count_samples_o;
    tmo_nx     = '0;
    clr_nx     = '0;
    win_nx     = window_cnt_o;
    timeout_nx = timeout_o;
    unique case (state)
      SCH_FILL: begin
        if (sound_valid_i) begin
          count_nx = count_samples_o + ONE16;
          if (count_nx == TOTAL16) begin
            state_nx = SCH_START;
          end
        end
      end
      SCH_START: begin
        state_nx = SCH_WAIT;
      end
      SCH_WAIT: begin
        // A done pulse takes priority over a timeout on the same cycle
        if (infer_done_i) begin
          state_nx = SCH_CLEAR;
          win_nx   = window_cnt_o + ONE16;
        end else if (TMO_ON && (tmo == TMO_LAST)) begin
          state_nx   = SCH_CLEAR;
          timeout_nx = 1'b1;
        end else begin
          tmo_nx = tmo + ONE16;
        end
      end
      SCH_CLEAR: begin
        if (clr == CLR_LAST) begin
          state_nx = SCH_FILL;
          count_nx = '0;
        end else begin
          clr_nx = clr + ONE16;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= SCH_FILL;
      count_samples_o <= '0;
      tmo             <= '0;
      clr             <= '0;
      window_cnt_o    <= '0;
      timeout_o       <= 1'b0;
      infer_start_o   <= 1'b0;
      ram_clear_o     <= 1'b0;
    end else begin
      state           <= state_nx;
      count_samples_o <= count_nx;
      tmo             <= tmo_nx;
      clr             <= clr_nx;
      window_cnt_o    <= win_nx;
      timeout_o       <= timeout_nx;
      // Registered strobes line up with the state they announce
      infer_start_o   <= (state_nx == SCH_START);
      ram_clear_o     <= (state_nx == SCH_CLEAR);
    end
  end

  window_scheduler_sat_counter #(
    .WIDTH(16)
  ) u_overrun (
    .clk   (clk_i),
    .clear (rst_i),
    .inc   (overrun),
    .value (overrun_cnt_o)
  );

endmodule

// File: tb/tb_window_scheduler.sv
// Bench for window_scheduler: vector table, directed corner
// sequences, randomized run against a timestamp model.
module tb_window_scheduler;

  localparam int SR   = 2;
  localparam int TW   = 3;
  localparam int TOT  = SR * TW;
  localparam int CLRC = 2;
  localparam int TMOC = 20;
  localparam int INF  = 1 << 30;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sv  = 1'b0;
  logic        dn  = 1'b0;
  logic        acc;
  logic [15:0] cnt;
  logic        st;
  logic        clr;
  logic [15:0] win;
  logic [15:0] ovr;
  logic        tmo;

  logic        rst2 = 1'b0;
  logic        sv2  = 1'b0;
  logic        dn2  = 1'b0;
  logic        acc2;
  logic [15:0] cnt2;
  logic        st2;
  logic        clr2;
  logic [15:0] win2;
  logic [15:0] ovr2;
  logic        tmo2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  window_scheduler #(
    .SAMPLING_RATE (SR),
    .TIME_WINDOW   (TW),
    .CLEAR_CYCLES  (CLRC),
    .TIMEOUT_CYCLES(TMOC)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .sound_valid_i  (sv),
    .sample_accept_o(acc),
    .count_samples_o(cnt),
    .infer_start_o  (st),
    .infer_done_i   (dn),
    .ram_clear_o    (clr),
    .window_cnt_o   (win),
    .overrun_cnt_o  (ovr),
    .timeout_o      (tmo)
  );

  // No-timeout instance, used to drive the overrun counter to saturation
  window_scheduler #(
    .SAMPLING_RATE (SR),
    .TIME_WINDOW   (TW),
    .CLEAR_CYCLES  (CLRC),
    .TIMEOUT_CYCLES(0)
  ) dut_sat (
    .clk_i          (clk),
    .rst_i          (rst2),
    .sound_valid_i  (sv2),
    .sample_accept_o(acc2),
    .count_samples_o(cnt2),
    .infer_start_o  (st2),
    .infer_done_i   (dn2),
    .ram_clear_o    (clr2),
    .window_cnt_o   (win2),
    .overrun_cnt_o  (ovr2),
    .timeout_o      (tmo2)
  );

  typedef struct {
    logic        v;
    logic        d;
    logic        acc;
    logic        st;
    logic        clr;
    logic [15:0] cnt;
    logic [15:0] win;
    logic [15:0] ovr;
    logic        tmo;
  } vec_t;

  vec_t tbl[25];

  // Timestamp reference model: c is the cycle index since reset
  int   c;
  int   t_start;
  int   t_clear;
  int   t_open;
  int   m_cnt;
  int   m_win;
  int   m_ovr;
  logic m_tmo;

  function automatic logic [63:0] pack(
    input logic a, input logic s, input logic k, input logic t,
    input logic [15:0] n, input logic [15:0] w, input logic [15:0] o);
    return {12'h0, a, s, k, t, n, w, o};
  endfunction

  function automatic logic [63:0] obs();
    return pack(acc, st, clr, tmo, cnt, win, ovr);
  endfunction

  function automatic logic [63:0] exp_out();
    logic a;
    logic s;
    logic k;
    a = (c >= t_open);
    s = (c == t_start);
    k = (c >= t_clear) && (c < t_clear + CLRC);
    return pack(a, s, k, m_tmo, 16'(m_cnt), 16'(m_win), 16'(m_ovr));
  endfunction

  task automatic m_reset();
    c       = 0;
    t_start = -10;
    t_clear = -10;
    t_open  = 0;
    m_cnt   = 0;
    m_win   = 0;
    m_ovr   = 0;
    m_tmo   = 1'b0;
  endtask

  task automatic m_end_wait();
    t_clear = c + 1;
    t_open  = c + 1 + CLRC;
  endtask

  task automatic m_step(input logic v, input logic d);
    logic open;
    logic waiting;
    open    = (c >= t_open);
    waiting = (c > t_start) && (c < t_clear);
    if (open) begin
      if (v) begin
        m_cnt++;
        if (m_cnt == TOT) begin
          t_start = c + 1;
          t_clear = INF;
          t_open  = INF;
        end
      end
    end else if (v && m_ovr < 65535) begin
      m_ovr++;
    end
    if (waiting) begin
      if (d) begin
        m_win = (m_win + 1) % 65536;
        m_end_wait();
      end else if (c == t_start + TMOC) begin
        m_tmo = 1'b1;
        m_end_wait();
      end
    end
    if (c + 1 == t_open) m_cnt = 0;
    c++;
  endtask

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, got, want, $time);
    end
  endtask

  task automatic step(input logic v, input logic d);
    sv = v;
    dn = d;
    @(posedge clk);
    #1;
    sv = 1'b0;
    dn = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b1, 1'b1);
    rst = 1'b0;
  endtask

  function automatic vec_t mk(
    input logic v, input logic d, input logic a, input logic s,
    input logic k, input int n, input int w, input int o);
    vec_t r;
    r.v   = v;
    r.d   = d;
    r.acc = a;
    r.st  = s;
    r.clr = k;
    r.cnt = 16'(n);
    r.win = 16'(w);
    r.ovr = 16'(o);
    r.tmo = 1'b0;
    return r;
  endfunction

  task automatic run_main();
    logic v;
    logic d;
    for (int i = 0; i < 15; i++) begin
      tbl[i] = mk((i % 3) == 0, 0, 1, 0, 0, i / 3 + 1, 0, 0);
    end
    tbl[15] = mk(1, 0, 0, 1, 0, 6, 0, 0);
    tbl[16] = mk(1, 0, 0, 0, 0, 6, 0, 1);
    tbl[17] = mk(1, 0, 0, 0, 0, 6, 0, 2);
    tbl[18] = mk(0, 0, 0, 0, 0, 6, 0, 2);
    tbl[19] = mk(0, 0, 0, 0, 0, 6, 0, 2);
    tbl[20] = mk(0, 0, 0, 0, 0, 6, 0, 2);
    tbl[21] = mk(0, 1, 0, 0, 1, 6, 1, 2);
    tbl[22] = mk(1, 0, 0, 0, 1, 6, 1, 3);
    tbl[23] = mk(1, 0, 1, 0, 0, 0, 1, 4);
    tbl[24] = mk(1, 0, 1, 0, 0, 1, 1, 4);

    do_reset();
    chk("reset", obs(), pack(1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 25; i++) begin
      step(tbl[i].v, tbl[i].d);
      chk($sformatf("vec%0d", i), obs(),
          pack(tbl[i].acc, tbl[i].st, tbl[i].clr, tbl[i].tmo,
               tbl[i].cnt, tbl[i].win, tbl[i].ovr));
    end

    // Timeout, then a normal window with timeout_o still set
    do_reset();
    repeat (TOT) step(1, 0);
    chk("tmo_start", obs(), pack(0, 1, 0, 0, 6, 0, 0));
    repeat (TMOC) step(0, 0);
    chk("tmo_last_wait", obs(), pack(0, 0, 0, 0, 6, 0, 0));
    step(0, 0);
    chk("tmo_fire", obs(), pack(0, 0, 1, 1, 6, 0, 0));
    step(0, 0);
    chk("tmo_clear2", obs(), pack(0, 0, 1, 1, 6, 0, 0));
    step(0, 0);
    chk("tmo_reopen", obs(), pack(1, 0, 0, 1, 0, 0, 0));
    repeat (TOT) step(1, 0);
    step(0, 0);
    step(0, 1);
    chk("tmo_next_win", obs(), pack(0, 0, 1, 1, 6, 1, 0));

    // Reset while waiting, with a sample on the same edge
    repeat (CLRC) step(0, 0);
    repeat (TOT) step(1, 0);
    step(0, 0);
    rst = 1'b1;
    step(1, 0);
    rst = 1'b0;
    chk("rst_wait", obs(), pack(1, 0, 0, 0, 0, 0, 0));
    step(0, 1);
    chk("done_in_fill", obs(), pack(1, 0, 0, 0, 0, 0, 0));
    step(0, 0);
    chk("done_in_fill2", obs(), pack(1, 0, 0, 0, 0, 0, 0));

    // Done coincident with START is ignored
    repeat (TOT) step(1, 0);
    chk("cs_start", obs(), pack(0, 1, 0, 0, 6, 0, 0));
    step(1, 1);
    chk("cs_done_ign", obs(), pack(0, 0, 0, 0, 6, 0, 1));
    step(1, 0);
    chk("cs_wait", obs(), pack(0, 0, 0, 0, 6, 0, 2));
    step(1, 1);
    chk("cs_done", obs(), pack(0, 0, 1, 0, 6, 1, 3));

    // Randomized run against the model
    do_reset();
    m_reset();
    for (int i = 0; i < 1500; i++) begin
      chk("rand", obs(), exp_out());
      v = 1'($urandom_range(0, 1));
      d = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        step(v, d);
        rst = 1'b0;
        m_reset();
      end else begin
        m_step(v, d);
        step(v, d);
      end
    end
  endtask

  task automatic run_sat();
    rst2 = 1'b1;
    @(posedge clk);
    #1;
    rst2 = 1'b0;
    sv2  = 1'b1;
    for (int n = 1; n <= 65546; n++) begin
      @(posedge clk);
      #1;
      if (n == 65540) chk("sat_fffe", {48'h0, ovr2}, 64'h0000_0000_0000_FFFE);
      if (n == 65541) chk("sat_ffff", {48'h0, ovr2}, 64'h0000_0000_0000_FFFF);
    end
    chk("sat_hold", {acc2, st2, clr2, tmo2, 12'h0, cnt2, win2, ovr2},
        {4'b0000, 12'h0, 16'd6, 16'd0, 16'hFFFF});
    sv2 = 1'b0;
  endtask

  initial begin
    fork
      run_main();
      run_sat();
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
